// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, flag positions,
// FSM states and operation-class helpers.
package alu_pkg;

   localparam logic [3:0] OP_PASS_A = 4'h0;
   localparam logic [3:0] OP_PASS_B = 4'h1;
   localparam logic [3:0] OP_NOT_A  = 4'h2;
   localparam logic [3:0] OP_NOT_B  = 4'h3;
   localparam logic [3:0] OP_ADD    = 4'h4;
   localparam logic [3:0] OP_ADC    = 4'h5;
   localparam logic [3:0] OP_SUB    = 4'h6;
   localparam logic [3:0] OP_AND    = 4'h7;
   localparam logic [3:0] OP_OR     = 4'h8;
   localparam logic [3:0] OP_XOR    = 4'h9;
   localparam logic [3:0] OP_NAND   = 4'hA;
   localparam logic [3:0] OP_LSL1   = 4'hB;
   localparam logic [3:0] OP_LSR1   = 4'hC;
   localparam logic [3:0] OP_ASR1   = 4'hD;
   localparam logic [3:0] OP_CSL    = 4'hE;
   localparam logic [3:0] OP_CSR    = 4'hF;

   localparam logic [4:0] FS_LSLN    = 5'b10000;
   localparam logic [4:0] FS_LSRN    = 5'b10001;
   localparam logic [4:0] FS_ASRN    = 5'b10010;
   localparam logic [4:0] FS_ROLN    = 5'b10011;
   localparam logic [4:0] FS_RORN    = 5'b10100;
   localparam logic [4:0] FS_MUL     = 5'b10101;
   localparam logic [4:0] FS_RSVD_LO = 5'b10110;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_O = 0;

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   function automatic logic is_multicycle(input logic [4:0] fs);
      return fs >= FS_LSLN;
   endfunction

   function automatic logic is_reserved(input logic [4:0] fs);
      return fs >= FS_RSVD_LO;
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// Combinational datapath for the sixteen single-cycle operations; reports the
// result, carry/overflow and which of those two flags the operation defines.
module alu_comb_core
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             c_we,
   output logic             o_we
);

   localparam int unsigned SW = WIDTH + 1;

   logic [WIDTH-1:0] addend;
   logic             add_cin;
   logic [SW-1:0]    sum;

   // Shared adder: subtraction is A + ~B + 1, so C=1 means no borrow.
   always_comb begin
      addend  = (op == OP_SUB) ? ~b : b;
      add_cin = (op == OP_SUB) ? 1'b1 : ((op == OP_ADC) ? c_in : 1'b0);
      sum     = {1'b0, a} + {1'b0, addend} + SW'(add_cin);
   end

   always_comb begin
      result   = '0;
      carry    = c_in;
      overflow = 1'b0;
      c_we     = 1'b0;
      o_we     = 1'b0;
      case (op)
         OP_PASS_A: result = a;
         OP_PASS_B: result = b;
         OP_NOT_A:  result = ~a;
         OP_NOT_B:  result = ~b;
         OP_ADD, OP_ADC, OP_SUB: begin
            result   = sum[WIDTH-1:0];
            carry    = sum[WIDTH];
            overflow = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            c_we     = 1'b1;
            o_we     = 1'b1;
         end
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_XOR:  result = a ^ b;
         OP_NAND: result = ~(a & b);
         OP_LSL1: begin
            result = {a[WIDTH-2:0], 1'b0};
            carry  = a[WIDTH-1];
            c_we   = 1'b1;
         end
         OP_LSR1: begin
            result = {1'b0, a[WIDTH-1:1]};
            carry  = a[0];
            c_we   = 1'b1;
         end
         OP_ASR1: begin
            result = {a[WIDTH-1], a[WIDTH-1:1]};
            carry  = a[0];
            c_we   = 1'b1;
         end
         OP_CSL: begin
            result = {a[WIDTH-2:0], c_in};
            carry  = a[WIDTH-1];
            c_we   = 1'b1;
         end
         OP_CSR: begin
            result = {c_in, a[WIDTH-1:1]};
            carry  = a[0];
            c_we   = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/multicycle_alu.sv
// Multi-cycle ALU: single-cycle ops complete at the edge after Start; N-bit
// shifts/rotates step one bit per cycle and MUL runs a WIDTH-step shift-add.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       FunSel,
   input  logic             WF,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       FlagsOut
);

   localparam int unsigned SHW = $clog2(WIDTH);
   localparam int unsigned CW  = SHW + 1;
   localparam int unsigned DW  = 2 * WIDTH;

   state_t           state, state_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [4:0]       op_q, op_next;
   logic             wf_q, wf_next;
   logic [WIDTH-1:0] sh_q, sh_next;
   logic [DW-1:0]    mcand_q, mcand_next;
   logic [DW-1:0]    acc_q, acc_next;
   logic [WIDTH-1:0] alu_next;
   logic [3:0]       flags_next;
   logic             done_next;
   logic             busy_next;

   logic [WIDTH-1:0] core_result;
   logic             core_carry, core_overflow, core_c_we, core_o_we;

   logic [SHW-1:0]   amount;
   logic [WIDTH-1:0] step;
   logic             step_c;
   logic [DW-1:0]    acc_step;

   logic [WIDTH-1:0] res;
   logic             c_new, o_new;
   logic             finish, wf_use, z_we, n_we, c_we, o_we;

   assign amount = B[SHW-1:0];

   alu_comb_core #(.WIDTH(WIDTH)) u_core (
      .a        (A),
      .b        (B),
      .c_in     (FlagsOut[FLAG_C]),
      .op       (FunSel[3:0]),
      .result   (core_result),
      .carry    (core_carry),
      .overflow (core_overflow),
      .c_we     (core_c_we),
      .o_we     (core_o_we)
   );

   // One step of the latched multi-cycle op; sh_q is the operand for shifts
   // and the remaining multiplier bits for MUL.
   always_comb begin
      step     = sh_q;
      step_c   = 1'b0;
      acc_step = acc_q;
      case (op_q)
         FS_LSLN: begin
            step   = {sh_q[WIDTH-2:0], 1'b0};
            step_c = sh_q[WIDTH-1];
         end
         FS_LSRN: begin
            step   = {1'b0, sh_q[WIDTH-1:1]};
            step_c = sh_q[0];
         end
         FS_ASRN: begin
            step   = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
            step_c = sh_q[0];
         end
         FS_ROLN: begin
            step   = {sh_q[WIDTH-2:0], sh_q[WIDTH-1]};
            step_c = sh_q[WIDTH-1];
         end
         FS_RORN: begin
            step   = {sh_q[0], sh_q[WIDTH-1:1]};
            step_c = sh_q[0];
         end
         FS_MUL: begin
            acc_step = sh_q[0] ? (acc_q + mcand_q) : acc_q;
            step     = {1'b0, sh_q[WIDTH-1:1]};
            step_c   = |acc_step[DW-1:WIDTH];
         end
         default: ;
      endcase
   end

   // Next-state, datapath loads and the completion/flag update.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      op_next    = op_q;
      wf_next    = wf_q;
      sh_next    = sh_q;
      mcand_next = mcand_q;
      acc_next   = acc_q;
      alu_next   = ALUOut;
      flags_next = FlagsOut;
      done_next  = 1'b0;
      res        = '0;
      c_new      = FlagsOut[FLAG_C];
      o_new      = FlagsOut[FLAG_O];
      finish     = 1'b0;
      wf_use     = 1'b0;
      z_we       = 1'b0;
      n_we       = 1'b0;
      c_we       = 1'b0;
      o_we       = 1'b0;

      case (state)
         IDLE: begin
            if (Start) begin
               if (!is_multicycle(FunSel)) begin
                  res    = core_result;
                  c_new  = core_carry;
                  o_new  = core_overflow;
                  c_we   = core_c_we;
                  o_we   = core_o_we;
                  z_we   = 1'b1;
                  n_we   = (FunSel[3:0] != OP_ASR1);
                  wf_use = WF;
                  finish = 1'b1;
               end else if (is_reserved(FunSel)) begin
                  finish = 1'b1;
               end else if ((FunSel == FS_MUL) || (amount != '0)) begin
                  state_next = RUN;
                  op_next    = FunSel;
                  wf_next    = WF;
                  if (FunSel == FS_MUL) begin
                     sh_next    = B;
                     mcand_next = {{WIDTH{1'b0}}, A};
                     acc_next   = '0;
                     cnt_next   = CW'(WIDTH);
                  end else begin
                     sh_next  = A;
                     cnt_next = CW'(amount);
                  end
               end else begin
                  // Zero-length shift: pass A through, carry untouched.
                  res    = A;
                  z_we   = 1'b1;
                  n_we   = (FunSel != FS_ASRN);
                  wf_use = WF;
                  finish = 1'b1;
               end
            end
         end
         RUN: begin
            cnt_next   = cnt - CW'(1);
            sh_next    = step;
            acc_next   = acc_step;
            mcand_next = mcand_q << 1;
            if (cnt == CW'(1)) begin
               state_next = IDLE;
               res        = (op_q == FS_MUL) ? acc_step[WIDTH-1:0] : step;
               c_new      = step_c;
               c_we       = 1'b1;
               z_we       = 1'b1;
               n_we       = (op_q != FS_ASRN);
               wf_use     = wf_q;
               finish     = 1'b1;
            end
         end
      endcase

      if (finish) begin
         alu_next  = res;
         done_next = 1'b1;
         if (wf_use) begin
            if (z_we) flags_next[FLAG_Z] = (res == '0);
            if (n_we) flags_next[FLAG_N] = res[WIDTH-1];
            if (c_we) flags_next[FLAG_C] = c_new;
            if (o_we) flags_next[FLAG_O] = o_new;
         end
      end

      busy_next = (state_next == RUN);
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op_q     <= '0;
         wf_q     <= 1'b0;
         sh_q     <= '0;
         mcand_q  <= '0;
         acc_q    <= '0;
         ALUOut   <= '0;
         FlagsOut <= '0;
         Done     <= 1'b0;
         Busy     <= 1'b0;
      end else begin
         state    <= state_next;
         cnt      <= cnt_next;
         op_q     <= op_next;
         wf_q     <= wf_next;
         sh_q     <= sh_next;
         mcand_q  <= mcand_next;
         acc_q    <= acc_next;
         ALUOut   <= alu_next;
         FlagsOut <= flags_next;
         Done     <= done_next;
         Busy     <= busy_next;
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Self-checking bench for multicycle_alu (WIDTH=32): directed vector table,
// randomized ops against an arithmetic reference model, and a reset abort.
`timescale 1ns/1ps
module tb_multicycle_alu;

   localparam int unsigned W = 32;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Start;
   logic [W-1:0]  A, B;
   logic [4:0]    FunSel;
   logic          WF;
   logic          Busy, Done;
   logic [W-1:0]  ALUOut;
   logic [3:0]    FlagsOut;

   int checks = 0;
   int errors = 0;

   logic [3:0]  m_flags;
   logic [31:0] last_res;

   typedef struct {
      logic [4:0]  fs;
      logic [31:0] a;
      logic [31:0] b;
      logic        wf;
      bit          ghost;
      logic [31:0] res;
      logic [3:0]  fl;
      int          lat;
   } vec_t;

   vec_t vecs[18];

   always #5 Clock = ~Clock;

   multicycle_alu #(.WIDTH(W)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Start    (Start),
      .A        (A),
      .B        (B),
      .FunSel   (FunSel),
      .WF       (WF),
      .Busy     (Busy),
      .Done     (Done),
      .ALUOut   (ALUOut),
      .FlagsOut (FlagsOut)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: whole-word arithmetic and shift operators, flags {Z,C,N,O}.
   function automatic void model(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                                 input logic wf, input logic [3:0] fin,
                                 output logic [31:0] r, output logic [3:0] fout, output int lat);
      logic [63:0] p;
      logic        c, o;
      bit          zw, nw;
      int          n;
      n = int'(b[4:0]);
      c = fin[2];
      o = fin[0];
      zw = 1'b1;
      nw = 1'b1;
      lat = 0;
      r = '0;
      p = '0;
      case (fs)
         5'd0: r = a;
         5'd1: r = b;
         5'd2: r = ~a;
         5'd3: r = ~b;
         5'd4, 5'd5: begin
            p = 64'(a) + 64'(b) + ((fs == 5'd5) ? 64'(fin[2]) : 64'd0);
            r = p[31:0];
            c = p[32];
            o = (a[31] == b[31]) && (r[31] != a[31]);
         end
         5'd6: begin
            r = a - b;
            c = (a >= b);
            o = (a[31] != b[31]) && (r[31] != a[31]);
         end
         5'd7:  r = a & b;
         5'd8:  r = a | b;
         5'd9:  r = a ^ b;
         5'd10: r = ~(a & b);
         5'd11: begin r = a << 1; c = a[31]; end
         5'd12: begin r = a >> 1; c = a[0]; end
         5'd13: begin r = 32'($signed(a) >>> 1); c = a[0]; nw = 1'b0; end
         5'd14: begin r = (a << 1) | 32'(fin[2]); c = a[31]; end
         5'd15: begin r = (a >> 1) | {fin[2], 31'd0}; c = a[0]; end
         5'd16: begin r = a << n; if (n != 0) c = a[32-n]; lat = n; end
         5'd17: begin r = a >> n; if (n != 0) c = a[n-1]; lat = n; end
         5'd18: begin r = 32'($signed(a) >>> n); if (n != 0) c = a[n-1]; nw = 1'b0; lat = n; end
         5'd19: begin
            r = a;
            if (n != 0) begin r = (a << n) | (a >> (32 - n)); c = r[0]; end
            lat = n;
         end
         5'd20: begin
            r = a;
            if (n != 0) begin r = (a >> n) | (a << (32 - n)); c = r[31]; end
            lat = n;
         end
         5'd21: begin
            p = 64'(a) * 64'(b);
            r = p[31:0];
            c = |p[63:32];
            lat = 32;
         end
         default: begin r = '0; zw = 1'b0; nw = 1'b0; end
      endcase
      fout = fin;
      if (wf && zw) begin
         fout[3] = (r == 32'd0);
         if (nw) fout[1] = r[31];
         fout[2] = c;
         fout[0] = o;
      end
   endfunction

   // Issue one op; operands are scrambled right after the Start edge.
   task automatic do_op(input logic [4:0] fs, input logic [31:0] a, input logic [31:0] b,
                        input logic wf, input bit ghost, input logic [31:0] prev,
                        output int lat, output int busy_n, output logic [31:0] res,
                        output logic [3:0] fl, output bit held);
      @(negedge Clock);
      FunSel = fs; A = a; B = b; WF = wf; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0; A = $urandom; B = $urandom; WF = ~wf; FunSel = 5'b00100;
      lat = 0; busy_n = 0; held = 1'b1;
      while (!Done && lat < 70) begin
         if (Busy) busy_n++;
         if (ALUOut !== prev) held = 1'b0;
         Start = (ghost && lat == 1);
         @(posedge Clock); #1;
         lat++;
      end
      Start = 1'b0;
      if (Busy) busy_n++;
      res = ALUOut;
      fl = FlagsOut;
   endtask

   task automatic run_check(input string tag, input logic [4:0] fs, input logic [31:0] a,
                            input logic [31:0] b, input logic wf, input bit ghost,
                            input logic [31:0] er, input logic [3:0] ef, input int el);
      int lat, busy_n;
      logic [31:0] res;
      logic [3:0] fl;
      bit held;
      do_op(fs, a, b, wf, ghost, last_res, lat, busy_n, res, fl, held);
      check($sformatf("%s fs=%0h res", tag, fs), 64'(res), 64'(er));
      check($sformatf("%s fs=%0h flags", tag, fs), 64'(fl), 64'(ef));
      check($sformatf("%s fs=%0h latency", tag, fs), 64'(lat), 64'(el));
      check($sformatf("%s fs=%0h busy_cycles", tag, fs), 64'(busy_n), 64'(el));
      check($sformatf("%s fs=%0h result_held", tag, fs), 64'(held), 64'd1);
      last_res = er;
   endtask

   initial begin
      logic [31:0] er, ra, rb;
      logic [3:0]  ef;
      logic [4:0]  rfs;
      logic        rwf;
      int          el;
      bit          seen;

      vecs[0]  = '{5'b00100, 32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000000, 4'b1100, 0};
      vecs[1]  = '{5'b00101, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 32'h00000003, 4'b0000, 0};
      vecs[2]  = '{5'b00110, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 4'b0101, 0};
      vecs[3]  = '{5'b10011, 32'h80000001, 32'h00000004, 1'b1, 1'b1, 32'h00000018, 4'b0001, 4};
      vecs[4]  = '{5'b10101, 32'h00010000, 32'h00010000, 1'b1, 1'b0, 32'h00000000, 4'b1101, 32};
      vecs[5]  = '{5'b10001, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 32'h12345678, 4'b0101, 0};
      vecs[6]  = '{5'b01111, 32'h00000002, 32'h00000000, 1'b1, 1'b0, 32'h80000001, 4'b0011, 0};
      vecs[7]  = '{5'b01101, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 32'hC0000000, 4'b0011, 0};
      vecs[8]  = '{5'b10110, 32'h0000FFFF, 32'h00000003, 1'b1, 1'b0, 32'h00000000, 4'b0011, 0};
      vecs[9]  = '{5'b01001, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b0, 1'b0, 32'h00000000, 4'b0011, 0};
      vecs[10] = '{5'b01010, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000000, 4'b1001, 0};
      vecs[11] = '{5'b10010, 32'h80000000, 32'h0000001F, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b0001, 31};
      vecs[12] = '{5'b10000, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h00000000, 4'b1101, 1};
      vecs[13] = '{5'b00110, 32'h00000005, 32'h00000005, 1'b1, 1'b0, 32'h00000000, 4'b1100, 0};
      vecs[14] = '{5'b00110, 32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 4'b0010, 0};
      vecs[15] = '{5'b10100, 32'h00000001, 32'h00000021, 1'b1, 1'b0, 32'h80000000, 4'b0110, 1};
      vecs[16] = '{5'b10101, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00000001, 4'b0100, 32};
      vecs[17] = '{5'b01110, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 4'b0100, 0};

      Reset = 1'b1; Start = 1'b0; A = '0; B = '0; FunSel = '0; WF = 1'b0;
      repeat (3) @(posedge Clock);
      #1;
      check("reset ALUOut", 64'(ALUOut), 64'd0);
      check("reset FlagsOut", 64'(FlagsOut), 64'd0);
      check("reset Busy", 64'(Busy), 64'd0);
      check("reset Done", 64'(Done), 64'd0);
      @(negedge Clock);
      Reset = 1'b0;
      last_res = '0;

      for (int i = 0; i < 18; i++)
         run_check($sformatf("vec%0d", i), vecs[i].fs, vecs[i].a, vecs[i].b, vecs[i].wf,
                   vecs[i].ghost, vecs[i].res, vecs[i].fl, vecs[i].lat);
      m_flags = vecs[17].fl;

      for (int i = 0; i < 150; i++) begin
         rfs = 5'($urandom_range(0, 31));
         ra  = $urandom;
         rb  = $urandom;
         if ($urandom_range(0, 3) == 0) rb = rb & 32'h00000007;
         rwf = 1'($urandom_range(0, 1));
         model(rfs, ra, rb, rwf, m_flags, er, ef, el);
         run_check($sformatf("rnd%0d", i), rfs, ra, rb, rwf, 1'b0, er, ef, el);
         m_flags = ef;
      end

      // Reset in the middle of a multiply aborts it without a Done.
      @(negedge Clock);
      FunSel = 5'b10101; A = 32'h00001234; B = 32'h00005678; WF = 1'b1; Start = 1'b1;
      @(posedge Clock); #1;
      Start = 1'b0;
      repeat (9) @(posedge Clock);
      #1;
      check("abort busy_before", 64'(Busy), 64'd1);
      #2 Reset = 1'b1;
      #1;
      check("abort Busy", 64'(Busy), 64'd0);
      check("abort Done", 64'(Done), 64'd0);
      check("abort ALUOut", 64'(ALUOut), 64'd0);
      check("abort FlagsOut", 64'(FlagsOut), 64'd0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge Clock); #1;
         if (Done) seen = 1'b1;
      end
      check("abort no_done", 64'(seen), 64'd0);
      last_res = '0;
      m_flags = '0;
      model(5'b00100, 32'd2, 32'd3, 1'b1, m_flags, er, ef, el);
      run_check("post_reset_add", 5'b00100, 32'd2, 32'd3, 1'b1, 1'b0, 32'd5, 4'b0000, 0);
      check("post_reset_add model", 64'(er), 64'd5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
